// File: rtl/scope_capture_if.sv
// Byte stream from the scope capture sequencer to the UART transmitter.
// A byte transfers on every clock edge where tx_valid and tx_ready are both
// high; while tx_valid is high and tx_ready is low the source holds tx_data
// stable and keeps tx_valid asserted.
interface scope_capture_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/scope_capture_ctrl.sv
// Scope acquisition sequencer: decimates the ADC bus into a circular buffer,
// waits for a level-crossing trigger with a programmable pre-trigger depth,
// then streams a header byte plus the frozen record over the tx interface.
// Optional feature macro: SCOPE_AUTO_TRIG_EN (forced trigger after
// AUTO_TIMEOUT sample ticks in WAIT_TRIG, header 0xA6 for forced captures).
// pretrig_i carries one extra bit so out-of-range requests can be clamped.
module scope_capture_ctrl #(
    parameter int DEPTH_LOG2   = 9,
    parameter int DIV_W        = 16,
    parameter int AUTO_TIMEOUT = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            adc_data_i,
    input  logic                  arm_i,
    input  logic [7:0]            trig_level_i,
    input  logic                  trig_rising_i,
    input  logic [DIV_W-1:0]      clk_div_i,
    input  logic [DEPTH_LOG2:0]   pretrig_i,
    output logic                  busy_o,
    output logic                  triggered_o,
    output logic [2:0]            state_o,
    scope_capture_if.master       tx
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] MAX_PRE = {1'b0, {DEPTH_LOG2{1'b1}}};
    localparam logic [DEPTH_LOG2:0] ONE_C   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DUMP = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DIV_W-1:0]        div_q, div_lat_q;
    logic [7:0]              lvl_q, prev_q, tx_data_q, rd_data_q;
    logic                    rising_q, prev_valid_q, fetch_q;
    logic                    tx_valid_q, busy_q, triggered_q;
    logic [DEPTH_LOG2:0]     pre_q, cnt_q, left_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, trig_addr_q, rd_addr_q;
    logic [7:0]              mem [DEPTH];

    logic [DEPTH_LOG2:0]     pre_d, post_total;
    logic                    run, tick, samp_en, edge_hit, fire;
    logic [7:0]              header;

    assign pre_d      = (pretrig_i > MAX_PRE) ? MAX_PRE : pretrig_i;
    assign post_total = DEPTH_C - pre_q;
    assign run        = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign tick       = run && (div_q == div_lat_q);
    // Once the post-trigger count is complete the buffer stops taking samples.
    assign samp_en    = tick && !((state_q == S_POST) && (cnt_q == post_total));
    assign edge_hit   = prev_valid_q &&
                        (rising_q ? ((prev_q < lvl_q) && (adc_data_i >= lvl_q))
                                  : ((prev_q > lvl_q) && (adc_data_i <= lvl_q)));

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            forced_q;
    logic            auto_hit;
    assign auto_hit = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
    assign fire     = edge_hit || auto_hit;
    assign header   = forced_q ? 8'hA6 : 8'hA5;
`else
    assign fire     = edge_hit;
    assign header   = 8'hA5;
`endif

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy_o      = busy_q;
    assign triggered_o = triggered_q;
    assign state_o     = state_q;

    // Sample buffer write and 1-cycle synchronous read port (no reset needed).
    always_ff @(posedge clk) begin
        if (samp_en) mem[wr_ptr_q] <= adc_data_i;
        rd_data_q <= mem[rd_addr_q];
    end

    // Capture sequencer: divider, pointers, trigger detect and byte dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            div_lat_q    <= '0;
            lvl_q        <= '0;
            rising_q     <= 1'b0;
            pre_q        <= '0;
            cnt_q        <= '0;
            left_q       <= '0;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            rd_addr_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            fetch_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            triggered_q  <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
            to_cnt_q     <= '0;
            forced_q     <= 1'b0;
`endif
        end else begin
            if (run) div_q <= tick ? '0 : div_q + 1'b1;
            if (samp_en) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                prev_q       <= adc_data_i;
                prev_valid_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        div_lat_q    <= clk_div_i;
                        lvl_q        <= trig_level_i;
                        rising_q     <= trig_rising_i;
                        pre_q        <= pre_d;
                        div_q        <= '0;
                        cnt_q        <= '0;
                        wr_ptr_q     <= '0;
                        prev_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
`ifdef SCOPE_AUTO_TRIG_EN
                        to_cnt_q     <= '0;
                        forced_q     <= 1'b0;
`endif
                        state_q      <= (pre_d == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE: begin
                    if (tick) begin
                        if (cnt_q + 1'b1 == pre_q) begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (tick) begin
`ifdef SCOPE_AUTO_TRIG_EN
                        to_cnt_q <= to_cnt_q + 1'b1;
                        forced_q <= !edge_hit;
`endif
                        if (fire) begin
                            trig_addr_q <= wr_ptr_q;
                            triggered_q <= 1'b1;
                            cnt_q       <= ONE_C;
                            state_q     <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (cnt_q == post_total) begin
                        state_q    <= S_DUMP;
                        tx_data_q  <= header;
                        tx_valid_q <= 1'b1;
                        rd_addr_q  <= trig_addr_q - pre_q[DEPTH_LOG2-1:0];
                        left_q     <= DEPTH_C;
                        fetch_q    <= 1'b0;
                    end else if (tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DUMP: begin
                    // After each accepted byte, spend one cycle letting the
                    // read port settle on rd_addr_q before presenting the next.
                    if (fetch_q) begin
                        tx_data_q  <= rd_data_q;
                        tx_valid_q <= 1'b1;
                        rd_addr_q  <= rd_addr_q + 1'b1;
                        left_q     <= left_q - 1'b1;
                        fetch_q    <= 1'b0;
                    end else if (tx_valid_q && tx.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (left_q == '0) begin
                            state_q     <= S_IDLE;
                            triggered_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            fetch_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
